// File: rtl/one_dimensional_router.sv
// One-dimensional mesh router node.
// Three input FIFOs (left, right, local) feed three registered outputs.
// Each head word is steered by its destination field against NODE_ID, and
// each output has its own round-robin arbiter, so up to three words move per
// clock. Words arriving at a full FIFO are dropped and counted (saturating).
// Port index order everywhere: 0 = left, 1 = right, 2 = local.
module one_dimensional_router #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 4,
   parameter int NODE_ID    = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              shiftInCLK,
   input  logic              shiftInRSTn,
   input  logic [DATA_W-1:0] shiftInLeftData,
   input  logic              shiftInLeftCS,
   input  logic [DATA_W-1:0] shiftInRightData,
   input  logic              shiftInRightCS,
   input  logic [DATA_W-1:0] shiftInData,
   input  logic              shiftInCS,
   output logic              shiftInLeftFull,
   output logic              shiftInRightFull,
   output logic              shiftInFull,
   output logic [DATA_W-1:0] shiftOutLeftData,
   output logic              shiftOutLeftCS,
   output logic [DATA_W-1:0] shiftOutRightData,
   output logic              shiftOutRightCS,
   output logic [DATA_W-1:0] shiftOutData,
   output logic              shiftOutCS,
   input  logic              shiftOutLeftStall,
   input  logic              shiftOutRightStall,
   input  logic              shiftOutStall,
   output logic [7:0]        dropCount
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0] MY_ADDR = ADDR_W'(NODE_ID);
   localparam logic [CNT_W-1:0]  OCC_FULL = CNT_W'(FIFO_DEPTH);

   localparam logic [1:0] P_LEFT  = 2'd0;
   localparam logic [1:0] P_RIGHT = 2'd1;
   localparam logic [1:0] P_LOCAL = 2'd2;

   logic [DATA_W-1:0] in_data [3];
   logic [2:0]        in_cs;
   logic [2:0]        out_stall;

   logic [DATA_W-1:0] fifo_mem [3][FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr [3];
   logic [PTR_W-1:0]  wr_ptr [3];
   logic [CNT_W-1:0]  occ [3];

   logic [2:0]        full;
   logic [2:0]        empty;
   logic [2:0]        push;
   logic [2:0]        pop;
   logic [2:0]        drop;
   logic [DATA_W-1:0] head [3];
   logic [1:0]        route [3];

   logic [2:0][2:0]   req;
   logic [2:0][2:0]   pick;
   logic [2:0]        grant_vld;
   logic [2:0][1:0]   grant_idx;
   logic [2:0][1:0]   prio;

   logic [DATA_W-1:0] out_data [3];
   logic [2:0]        out_cs;

   logic [1:0]        drop_num;
   logic [8:0]        drop_sum;
   logic [7:0]        drop_cnt;

   assign in_data[0] = shiftInLeftData;
   assign in_data[1] = shiftInRightData;
   assign in_data[2] = shiftInData;
   assign in_cs      = {shiftInCS, shiftInRightCS, shiftInLeftCS};
   assign out_stall  = {shiftOutStall, shiftOutRightStall, shiftOutLeftStall};

   // Round-robin pick: returns {valid, index}, searching from prio_v upward
   // with wrap over the three inputs.
   function automatic logic [2:0] rr_pick(input logic [2:0] req_v,
                                          input logic [1:0] prio_v);
      logic [1:0] c0;
      logic [1:0] c1;
      logic [1:0] c2;
      c0 = 2'd0;
      c1 = 2'd1;
      c2 = 2'd2;
      rr_pick = {1'b0, prio_v};
      case (prio_v)
         2'd1:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
         2'd2:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
         default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
      endcase
      if (req_v[c0])      rr_pick = {1'b1, c0};
      else if (req_v[c1]) rr_pick = {1'b1, c1};
      else if (req_v[c2]) rr_pick = {1'b1, c2};
   endfunction

   // FIFO status, accept/drop decision and head routing per input.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         full[i]  = (occ[i] == OCC_FULL);
         empty[i] = (occ[i] == '0);
         push[i]  = in_cs[i] && !full[i];
         drop[i]  = in_cs[i] && full[i];
         head[i]  = fifo_mem[i][rd_ptr[i]];
         if (head[i][DATA_W-1 -: ADDR_W] < MY_ADDR)
            route[i] = P_LEFT;
         else if (head[i][DATA_W-1 -: ADDR_W] > MY_ADDR)
            route[i] = P_RIGHT;
         else
            route[i] = P_LOCAL;
      end
   end

   // Per-output request vectors and independent round-robin grants.
   always_comb begin
      for (int o = 0; o < 3; o++) begin
         for (int i = 0; i < 3; i++)
            req[o][i] = !empty[i] && (route[i] == 2'(o));
         pick[o]      = rr_pick(req[o], prio[o]);
         grant_vld[o] = pick[o][2] && !out_stall[o];
         grant_idx[o] = pick[o][1:0];
      end
   end

   // A FIFO pops when the output its head routes to grants it.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         pop[i] = 1'b0;
         for (int o = 0; o < 3; o++)
            if (grant_vld[o] && (grant_idx[o] == 2'(i)))
               pop[i] = 1'b1;
      end
   end

   // Number of words dropped this edge, added onto the running count.
   always_comb begin
      drop_num = {1'b0, drop[0]} + {1'b0, drop[1]} + {1'b0, drop[2]};
      drop_sum = {1'b0, drop_cnt} + {7'd0, drop_num};
   end

   // FIFO storage; contents are don't-care while empty, so no reset.
   always_ff @(posedge shiftInCLK) begin
      for (int i = 0; i < 3; i++)
         if (push[i])
            fifo_mem[i][wr_ptr[i]] <= in_data[i];
   end

   // FIFO pointers and occupancy; pointers wrap naturally (depth is 2^n).
   always_ff @(posedge shiftInCLK or negedge shiftInRSTn) begin
      if (!shiftInRSTn) begin
         for (int i = 0; i < 3; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            occ[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (push[i])
               wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
            if (pop[i])
               rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
            case ({push[i], pop[i]})
               2'b10:   occ[i] <= occ[i] + CNT_W'(1);
               2'b01:   occ[i] <= occ[i] - CNT_W'(1);
               default: occ[i] <= occ[i];
            endcase
         end
      end
   end

   // Output registers and arbiter priority rotation.
   always_ff @(posedge shiftInCLK or negedge shiftInRSTn) begin
      if (!shiftInRSTn) begin
         for (int o = 0; o < 3; o++) begin
            out_data[o] <= '0;
            out_cs[o]   <= 1'b0;
            prio[o]     <= P_LEFT;
         end
      end else begin
         for (int o = 0; o < 3; o++) begin
            if (grant_vld[o]) begin
               out_data[o] <= head[grant_idx[o]];
               out_cs[o]   <= 1'b1;
               prio[o]     <= (grant_idx[o] == P_LOCAL) ? P_LEFT : grant_idx[o] + 2'd1;
            end else begin
               out_cs[o]   <= 1'b0;
            end
         end
      end
   end

   // Saturating drop counter.
   always_ff @(posedge shiftInCLK or negedge shiftInRSTn) begin
      if (!shiftInRSTn)
         drop_cnt <= 8'd0;
      else if (drop_sum > 9'd255)
         drop_cnt <= 8'hFF;
      else
         drop_cnt <= drop_sum[7:0];
   end

   assign shiftInLeftFull   = full[0];
   assign shiftInRightFull  = full[1];
   assign shiftInFull       = full[2];
   assign shiftOutLeftData  = out_data[0];
   assign shiftOutLeftCS    = out_cs[0];
   assign shiftOutRightData = out_data[1];
   assign shiftOutRightCS   = out_cs[1];
   assign shiftOutData      = out_data[2];
   assign shiftOutCS        = out_cs[2];
   assign dropCount         = drop_cnt;

endmodule

// File: doc/one_dimensional_router.md
ONE_DIMENSIONAL_ROUTER -- requirements
Module: one_dimensional_router

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of every data port.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning the destination field width, taken from data bits [DATA_W-1 : DATA_W-ADDR_W].
REQ-003 The block SHALL have parameter NODE_ID, default 0, meaning this node's address.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, meaning per-input FIFO depth; power of two, at least 2.

Interface
REQ-005 The block SHALL have port shiftInCLK, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-006 The block SHALL have port shiftInRSTn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have ports shiftInLeftData/shiftInLeftCS, input, DATA_W/1 bits: word and valid strobe from the left neighbour.
REQ-008 The block SHALL have ports shiftInRightData/shiftInRightCS, input, DATA_W/1 bits: word and valid strobe from the right neighbour.
REQ-009 The block SHALL have ports shiftInData/shiftInCS, input, DATA_W/1 bits: word and valid strobe from the local endpoint.
REQ-010 The block SHALL have ports shiftInLeftFull/shiftInRightFull/shiftInFull, output, 1 bit each: the matching input FIFO is full.
REQ-011 The block SHALL have ports shiftOutLeftData/shiftOutLeftCS, output, DATA_W/1 bits: word and valid strobe toward the left neighbour.
REQ-012 The block SHALL have ports shiftOutRightData/shiftOutRightCS, output, DATA_W/1 bits: word and valid strobe toward the right neighbour.
REQ-013 The block SHALL have ports shiftOutData/shiftOutCS, output, DATA_W/1 bits: word and valid strobe toward the local endpoint.
REQ-014 The block SHALL have ports shiftOutLeftStall/shiftOutRightStall/shiftOutStall, input, 1 bit each: the downstream receiver cannot accept.
REQ-015 The block SHALL have port dropCount, output, 8 bits: saturating count of words dropped at full FIFOs.

Function
REQ-016 Each input SHALL write its Data into its FIFO on a rising edge where its CS=1 and its FIFO is not full; one word per edge per input.
REQ-017 A CS=1 on an input whose FIFO is full at that edge SHALL drop the word, even if the same FIFO pops that edge, and increment dropCount, saturating at 255.
REQ-018 Multiple simultaneous drops in one edge SHALL each increment dropCount, subject to saturation.
REQ-019 Full SHALL equal (occupancy == FIFO_DEPTH), taken from registered occupancy.
REQ-020 The head word SHALL route by destination field D: D<NODE_ID to the left output, D>NODE_ID to the right output, D==NODE_ID to the local output, regardless of arrival port (U-turns allowed).
REQ-021 Each output SHALL be owned by a round-robin arbiter over inputs in the order 0=left, 1=right, 2=local.
REQ-022 At each edge where an output's Stall=0 and at least one non-empty FIFO head routes to it, the arbiter SHALL grant one requester, pop that FIFO, register the word onto the output Data, and drive the output CS=1 for exactly that cycle.
REQ-023 After granting input i, that arbiter's highest priority SHALL become (i+1) mod 3; with no grant, its priority SHALL be unchanged.
REQ-024 If an output has no grant at an edge (idle or Stall=1), its CS SHALL be 0 and its Data SHALL hold its last value.
REQ-025 The three outputs SHALL arbitrate independently and in parallel, so up to three pops occur per edge.
REQ-026 A given FIFO SHALL pop at most once per edge, because its head routes to exactly one output.
REQ-027 Minimum latency SHALL be one edge: a word written at edge N into an empty FIFO appears with CS=1 after edge N+1.
REQ-028 Each FIFO SHALL preserve order, with pointers wrapping modulo FIFO_DEPTH.
REQ-029 A simultaneous push and pop on a non-full FIFO SHALL leave its occupancy unchanged.

Reset
REQ-030 While shiftInRSTn=0, regardless of clock, all FIFOs SHALL be emptied, all Full and all output CS SHALL be 0, all output Data SHALL be 0, dropCount SHALL be 0, and all arbiter priorities SHALL be reset to left.
REQ-031 Words in flight at reset SHALL be discarded.
REQ-032 After reset release, no output CS SHALL assert until a new input CS is accepted.

Verification (NODE_ID=4, ADDR_W=4, DATA_W=32, FIFO_DEPTH=4)
REQ-033 The bench SHALL cover: shiftInData=0x2000_0042, shiftInCS pulsed once -> shiftOutLeftCS=1 for one cycle exactly one edge later with shiftOutLeftData=0x2000_0042; the other CS stay 0.
REQ-034 The bench SHALL cover: left 0x4000_0049, right 0x4000_0073, local 0x4000_0089 strobed at the same edge -> shiftOutCS high on three consecutive cycles carrying 0x...49, 0x...73, 0x...89; a following three-way contest grants left, then right, then local again.
REQ-035 The bench SHALL cover: left-in 0x7000_0001 and right-in 0x1000_0002 strobed at the same edge -> shiftOutRightData=0x7000_0001 and shiftOutLeftData=0x1000_0002 with both CS high on the same cycle.
REQ-036 The bench SHALL cover: shiftOutRightStall=1 and five local words 0x9000_0001..0x9000_0005 -> shiftInFull=1 after the fourth, the fifth dropped, dropCount=1; on stall release, 0x9000_0001..0x9000_0004 are emitted in order on four consecutive cycles, then shiftInFull=0.
REQ-037 The bench SHALL cover: shiftInRSTn pulsed low mid-cycle with two words queued -> all CS, Full and dropCount read 0 immediately; no word emerges after release.
REQ-038 The bench SHALL cover: 300 strobes into a full FIFO -> dropCount saturates at 255.
